// File: rtl/sub_word_pkg.sv
// Shared AES constants: forward S-box table (FIPS-197), reusable by SubBytes and
// inverse-S-box blocks.
package sub_word_pkg;

    localparam logic [7:0] SboxTable [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox_lookup(input logic [7:0] b);
        return SboxTable[b];
    endfunction

endpackage

// File: rtl/sub_word_sbox.sv
// Combinational AES forward S-box: one byte in, one byte out.
module sbox
    import sub_word_pkg::*;
(
    input  logic [7:0] in_i,
    output logic [7:0] out_o
);

    assign out_o = sbox_lookup(in_i);

endmodule

// File: rtl/sub_word.sv
// AES SubWord: four independent S-box lanes with a registered, 1-cycle-latency output.
module sub_word
    import sub_word_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       valid_in,
    input  logic [7:0] S0_in,
    input  logic [7:0] S1_in,
    input  logic [7:0] S2_in,
    input  logic [7:0] S3_in,
    output logic [7:0] D0_out,
    output logic [7:0] D1_out,
    output logic [7:0] D2_out,
    output logic [7:0] D3_out,
    output logic       valid_out
);

    logic [7:0]  sub0, sub1, sub2, sub3;
    logic [31:0] d_d, d_q;
    logic        valid_d, valid_q;

    sbox u_sbox0 (.in_i(S0_in), .out_o(sub0));
    sbox u_sbox1 (.in_i(S1_in), .out_o(sub1));
    sbox u_sbox2 (.in_i(S2_in), .out_o(sub2));
    sbox u_sbox3 (.in_i(S3_in), .out_o(sub3));

    // Data only loads on a valid word, so undriven inputs while idle never reach the outputs.
    always_comb begin
        d_d     = d_q;
        valid_d = valid_in;
        if (valid_in) begin
            d_d = {sub0, sub1, sub2, sub3};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            d_q     <= d_d;
            valid_q <= valid_d;
        end
    end

    assign D0_out    = d_q[31:24];
    assign D1_out    = d_q[23:16];
    assign D2_out    = d_q[15:8];
    assign D3_out    = d_q[7:0];
    assign valid_out = valid_q;

endmodule

// File: tb/tb_sub_word.sv
// Scoreboard bench for sub_word; the reference S-box is derived from GF(2^8) inversion
// followed by the AES affine transform.
module tb_sub_word;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       valid_in = 1'b0;
    logic [7:0] s0 = '0, s1 = '0, s2 = '0, s3 = '0;
    logic [7:0] d0, d1, d2, d3;
    logic       valid_out;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  ref_tab[256];

    sub_word dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_in (valid_in),
        .S0_in    (s0),
        .S1_in    (s1),
        .S2_in    (s2),
        .S3_in    (s3),
        .D0_out   (d0),
        .D1_out   (d1),
        .D2_out   (d2),
        .D3_out   (d3),
        .valid_out(valid_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_ref();
        logic [7:0] inv, x;
        for (int v = 0; v < 256; v++) begin
            inv = 8'h00;
            for (int c = 1; c < 256; c++) begin
                if (gmul(8'(v), 8'(c)) == 8'h01) inv = 8'(c);
            end
            x = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            ref_tab[v] = x;
        end
    endtask

    function automatic logic [31:0] model_word(input logic [31:0] w);
        return {ref_tab[w[31:24]], ref_tab[w[23:16]], ref_tab[w[15:8]], ref_tab[w[7:0]]};
    endfunction

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one word at the falling edge; a valid word queues its expected result.
    task automatic drive(input logic v, input logic [31:0] w, input logic [31:0] exp);
        @(negedge clk);
        valid_in = v;
        {s0, s1, s2, s3} = w;
        if (v) exp_q.push_back(exp);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, $urandom, 32'h0);
        end
    endtask

    // Monitor: pops on every valid result, otherwise checks hold / reset values.
    initial begin
        logic [31:0] last_exp;
        logic [31:0] got;
        last_exp = '0;
        forever begin
            @(posedge clk);
            #1;
            got = {d0, d1, d2, d3};
            if (!rst_n) begin
                last_exp = '0;
                check("in_reset", {valid_out, got}, 33'h0);
            end else if (valid_out) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_valid: got %h expected no output", got);
                end else begin
                    last_exp = exp_q.pop_front();
                    check("data", {1'b1, got}, {1'b1, last_exp});
                end
            end else begin
                check("hold", {1'b0, got}, {1'b0, last_exp});
            end
        end
    end

    initial begin
        logic [31:0] w;
        build_ref();

        // Asynchronous reset before any clock edge, with random inputs presented.
        valid_in = 1'b1;
        {s0, s1, s2, s3} = $urandom;
        #1 rst_n = 1'b0;
        #2;
        check("async_reset", {valid_out, d0, d1, d2, d3}, 33'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            {s0, s1, s2, s3} = $urandom;
        end

        // Release with a valid word at the first edge: it must be captured.
        @(negedge clk);
        rst_n = 1'b1;
        valid_in = 1'b1;
        {s0, s1, s2, s3} = 32'h00010203;
        exp_q.push_back(32'h637c777b);

        drive(1'b1, 32'h20467567, 32'hb75a9d85);
        drive(1'b1, 32'h00000000, 32'h63636363);
        drive(1'b1, 32'hffffffff, 32'h16161616);
        drive(1'b1, 32'h54776f20, 32'h20f5a8b7);

        // Hold with changing and undriven inputs.
        idle(3);
        @(negedge clk);
        valid_in = 1'b0;
        {s0, s1, s2, s3} = 'x;
        idle(1);

        // Exhaustive sweep: every value on every lane.
        for (int i = 0; i < 256; i++) begin
            w = {8'(i), 8'(i) ^ 8'h5a, 8'(255 - i), 8'(i + 37)};
            drive(1'b1, w, model_word(w));
        end
        idle(2);

        // Mid-stream reset one cycle after a valid word.
        w = $urandom;
        drive(1'b1, w, model_word(w));
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midstream_reset", {valid_out, d0, d1, d2, d3}, 33'h0);
        @(negedge clk);
        valid_in = 1'b0;
        {s0, s1, s2, s3} = $urandom;
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);

        // Random traffic, mostly back-to-back.
        for (int i = 0; i < 300; i++) begin
            w = $urandom;
            if ($urandom_range(0, 9) < 7) drive(1'b1, w, model_word(w));
            else drive(1'b0, w, 32'h0);
        end
        idle(3);

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results outstanding, expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sub_word.md
SUB_WORD -- requirements
Module: sub_word

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 valid_in  input  1  high = the S0_in..S3_in word is presented this cycle.
REQ-005 S0_in  input  8  word byte 0 (most significant byte of the 32-bit word).
REQ-006 S1_in  input  8  word byte 1.
REQ-007 S2_in  input  8  word byte 2.
REQ-008 S3_in  input  8  word byte 3 (least significant byte).
REQ-009 D0_out  output  8  S-box(S0_in), registered.
REQ-010 D1_out  output  8  S-box(S1_in), registered.
REQ-011 D2_out  output  8  S-box(S2_in), registered.
REQ-012 D3_out  output  8  S-box(S3_in), registered.
REQ-013 valid_out  output  1  high = D0_out..D3_out hold a result produced from a valid_in word.

Function
REQ-014 SHALL apply the AES forward S-box (FIPS-197 Fig. 7) independently to each byte: Dn = SBOX(Sn).
REQ-015 The S-box SHALL be a full 256-entry constant lookup; bytes SHALL NOT interact (no rotation, no Rcon).
REQ-016 Latency SHALL be exactly 1 clk: inputs sampled on edge k with valid_in=1 appear on D*_out after edge k.
REQ-017 valid_out SHALL equal valid_in registered by one cycle.
REQ-018 When valid_in=0 at an edge, D0_out..D3_out SHALL hold their previous values; valid_out SHALL go to 0.
REQ-019 Back-to-back valid_in=1 cycles SHALL be accepted every cycle (throughput 1 word/clk), with no stall or backpressure.
REQ-020 Any byte value 0x00..0xFF SHALL be legal; there are no invalid-input cases.
REQ-021 X/Z on S*_in while valid_in=0 SHALL NOT affect the outputs.

Reset
REQ-022 While rst_n=0: D0_out..D3_out SHALL be 8'h00 and valid_out SHALL be 0, immediately and without a clock edge.
REQ-023 Deassertion of rst_n SHALL take effect at the first rising clk after release; a valid_in word presented at that edge SHALL be captured.
REQ-024 Assertion of rst_n mid-stream SHALL discard any in-flight result; no output SHALL reappear after release.

Structure
REQ-025 The 256-byte S-box table SHALL be a combinational sub-module named sbox (8-bit in, 8-bit out), instantiated 4 times.
REQ-026 sub_word SHALL contain only the 4 sbox instances plus the output and valid registers.
REQ-027 The S-box constant table SHALL live in a shared AES package so that inverse-S-box and SubBytes blocks can reuse it; sub_word SHALL define no local constants.

Verification
REQ-028 Reset: hold rst_n=0 with random S*_in -> D*_out=00 00 00 00, valid_out=0, with no clock required.
REQ-029 Input 00 01 02 03 with valid_in=1 -> after 1 clk: 63 7c 77 7b, valid_out=1.
REQ-030 Input 20 46 75 67 (RotWord of a key word) -> b7 5a 9d 85; then input 00 00 00 00 -> 63 63 63 63 on the next cycle.
REQ-031 Input FF FF FF FF -> 16 16 16 16; then input 54 77 6F 20 -> 20 f5 a8 b7, back-to-back on consecutive clks.
REQ-032 Hold: drive valid_in=0 with inputs changed -> D*_out unchanged, valid_out=0; exhaustive sweep of 0x00..0xFF on each byte lane matches the reference table.
REQ-033 Mid-stream reset: assert rst_n=0 one cycle after a valid word -> outputs go to 0 asynchronously; after release, outputs stay 0 until the next valid_in.
